// File: rtl/lr35902_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lr35902_irq_ctrl
// Purpose  : LR35902 interrupt controller. Latches peripheral interrupt
//            requests into IF (FF0F), holds the IE mask (FFFF), selects the
//            highest-priority enabled pending request and runs the
//            request/acknowledge handshake with the CPU.
// Ports    : clk_i       system clock
//            reset_i     synchronous active-high reset
//            dout_o[7:0] registered read data (adr 0 = IF, adr 1 = IE)
//            din_i[7:0]  write data
//            adr_i       register select
//            write_i     write strobe, commits on its falling edge
//            irq_in_i[4:0] requests: VBLANK, STAT, TIMER, SERIAL, JOYPAD
//            int_req_o   enabled interrupt pending and no grant active
//            int_ack_i   CPU acknowledge level
//            int_vec_o[7:0] dispatch vector, valid while granted
// Config   : define LR35902_IRQ_EDGE_EN to treat irq_in_i as levels that are
//            edge-detected internally; otherwise every high cycle sets IF.
// Revision : 1.0 - initial release
// ============================================================================
module lr35902_irq_ctrl (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [7:0] dout_o,
  input  logic [7:0] din_i,
  input  logic       adr_i,
  input  logic       write_i,
  input  logic [4:0] irq_in_i,
  output logic       int_req_o,
  input  logic       int_ack_i,
  output logic [7:0] int_vec_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic [7:0] int_vec_q, int_vec_d;
  logic [7:0] dout_q;
  logic       pwrite_q;
  logic       pack_q;

  logic [4:0] w_set;
  logic [4:0] w_pending;
  logic [4:0] w_clr;
  logic [2:0] w_n;
  logic       w_commit;

`ifdef LR35902_IRQ_EDGE_EN
  logic [4:0] irq_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) irq_prev_q <= 5'b0;
    else         irq_prev_q <= irq_in_i;
  end

  // Only a rising edge of a level request sets the flag.
  assign w_set = irq_in_i & ~irq_prev_q;
`else
  assign w_set = irq_in_i;
`endif

  assign w_pending = if_q & ie_q[4:0];
  assign w_commit  = pwrite_q & ~write_i;
  assign int_req_o = (state_q == ST_IDLE) && (|w_pending);
  assign dout_o    = dout_q;
  assign int_vec_o = int_vec_q;

  // Lowest set pending bit: scan downward so the lowest index is written last.
  always_comb begin
    w_n = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (w_pending[i]) w_n = i[2:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    int_vec_d = int_vec_q;
    w_clr     = 5'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (int_ack_i && !pack_q) begin
          state_d = ST_GRANT;
          if (|w_pending) begin
            int_vec_d = 8'h40 + {2'b00, w_n, 3'b000};
            w_clr     = 5'b00001 << w_n;
          end else begin
            // Request vanished before acknowledge: cancelled dispatch.
            int_vec_d = 8'h00;
          end
        end
      end
      ST_GRANT: begin
        if (!int_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request always wins over a same-cycle clear from write or grant.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (w_commit) begin
      if (adr_i) ie_d = din_i;
      else       if_d = din_i[4:0];
    end
    if_d = (if_d & ~w_clr) | w_set;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      if_q      <= 5'b0;
      ie_q      <= 8'h00;
      int_vec_q <= 8'h00;
      dout_q    <= 8'h00;
      pwrite_q  <= 1'b0;
      pack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      int_vec_q <= int_vec_d;
      dout_q    <= adr_i ? ie_q : {3'b111, if_q};
      pwrite_q  <= write_i;
      pack_q    <= int_ack_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lr35902_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lr35902_irq_ctrl
// Purpose  : Self-checking bench for lr35902_irq_ctrl. A reference model
//            predicts dout/int_req/int_vec after every clock edge and queues
//            the prediction; a monitor compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lr35902_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dout;
  logic [7:0] din = 8'h00;
  logic       adr = 1'b0;
  logic       write = 1'b0;
  logic [4:0] irq_in = 5'b0;
  logic       int_req;
  logic       int_ack = 1'b0;
  logic [7:0] int_vec;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] dout;
    logic       req;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [4:0] m_if = 5'b0;
  logic [7:0] m_ie = 8'h00;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] m_vec = 8'h00;
  logic       m_pw = 1'b0;
  logic       m_pack = 1'b0;
  logic       m_grant = 1'b0;
  logic [4:0] m_prev = 5'b0;

  lr35902_irq_ctrl dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .dout_o    (dout),
    .din_i     (din),
    .adr_i     (adr),
    .write_i   (write),
    .irq_in_i  (irq_in),
    .int_req_o (int_req),
    .int_ack_i (int_ack),
    .int_vec_o (int_vec)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one prediction per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check8("dout", dout, e.dout);
      check8("int_req", {7'b0, int_req}, {7'b0, e.req});
      check8("int_vec", int_vec, e.vec);
    end
  end

  // Behavioural model of one clock edge, from the register rules.
  task automatic model_update();
    logic [4:0] set, pend, nif;
    logic [7:0] nie, ndout;
    int n;
    exp_t e;
    if (reset) begin
      m_if = 5'b0; m_ie = 8'h00; m_dout = 8'h00; m_vec = 8'h00;
      m_pw = 1'b0; m_pack = 1'b0; m_grant = 1'b0; m_prev = 5'b0;
    end else begin
`ifdef LR35902_IRQ_EDGE_EN
      set = irq_in & ~m_prev;
`else
      set = irq_in;
`endif
      pend  = m_if & m_ie[4:0];
      ndout = adr ? m_ie : {3'b111, m_if};
      nif   = m_if;
      nie   = m_ie;
      if (m_pw && !write) begin
        if (adr) nie = din;
        else     nif = din[4:0];
      end
      if (!m_grant && int_ack && !m_pack) begin
        m_grant = 1'b1;
        if (pend == 5'b0) begin
          m_vec = 8'h00;
        end else begin
          n = 0;
          while (!pend[n]) n++;
          m_vec = 8'(64 + 8 * n);
          nif[n] = 1'b0;
        end
      end else if (m_grant && !int_ack) begin
        m_grant = 1'b0;
      end
      m_if   = nif | set;
      m_ie   = nie;
      m_dout = ndout;
      m_pw   = write;
      m_pack = int_ack;
      m_prev = irq_in;
    end
    e.dout = m_dout;
    e.req  = !m_grant && (|(m_if & m_ie[4:0]));
    e.vec  = m_vec;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic a,
                      input logic w, input logic [4:0] irq, input logic ack);
    @(negedge clk);
    #1;
    reset = r; din = d; adr = a; write = w; irq_in = irq; int_ack = ack;
    @(posedge clk);
    model_update();
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    step(1'b0, d, a, 1'b1, 5'b0, 1'b0);
    step(1'b0, d, a, 1'b0, 5'b0, 1'b0);
  endtask

  initial begin
    logic       r_ack;
    int         ack_cnt;
    logic       r_wr;
    // Reset defaults
    step(1'b1, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Priority dispatch: TIMER then SERIAL
    wr(1'b1, 8'h1F);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b01100, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Masking and cancelled dispatch
    wr(1'b1, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b01000, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Set-wins: IF write commits in the same cycle as a TIMER pulse
    step(1'b0, 8'h00, 1'b0, 1'b1, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b00100, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Grant collision: VBLANK re-pulsed in the grant cycle
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b00001, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b00001, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Reset mid-grant
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // JOYPAD held high across a grant
    wr(1'b1, 8'h10);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b10000, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 5'b0, 1'b0);

    // Randomized traffic; ack obeys the CPU rule of at least 2 high cycles.
    r_ack   = 1'b0;
    ack_cnt = 3;
    r_wr    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ack_cnt == 0) begin
        r_ack   = ~r_ack;
        ack_cnt = r_ack ? int'($urandom_range(2, 5)) : int'($urandom_range(1, 6));
      end
      ack_cnt--;
      if ($urandom_range(0, 3) == 0) r_wr = ~r_wr;
      step(($urandom_range(0, 199) == 0),
           8'($urandom),
           1'($urandom),
           r_wr,
           5'($urandom & $urandom & $urandom),
           r_ack);
    end

    repeat (3) @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
